// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for hazard_stall_unit: ID/EX and IF/ID hazard fields going in,
// PC/IF-ID/ID-EX controls and statistics coming out.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             stalling;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt, branch_taken,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt, branch_taken,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall and branch-flush control for the five-stage pipeline.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_stall_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic              clk,
  input logic              reset_n,
  hazard_stall_unit_if.slave bus
);
  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       hazard;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling;

  assign hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                  ((bus.id_ex_rt == bus.if_id_rs) ||
                   (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    stalling     = 1'b0;
    if (!reset_n) begin
      // Hold the front end frozen and flushed while reset is asserted.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = 4'd0;
    end else if (bus.branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = 4'd0;
    end else if (state == STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stalling     = 1'b1;
      rem_nxt      = rem - 4'd1;
      if (rem == 4'd1) state_nxt = RUN;
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stalling     = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nxt = STALL;
        rem_nxt   = REM_INIT;
      end
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.stalling     = stalling;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stalling && !(&stall_q))          stall_q <= stall_q + CNT_W'(1);
      if (bus.branch_taken && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: one unit with a single-cycle stall (32-bit counters) and one with a
// three-cycle stall (4-bit counters, used for saturation).
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, stalling}
  localparam logic [4:0] PASS  = 5'b11000;
  localparam logic [4:0] STALV = 5'b00101;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] RSTV  = 5'b00110;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(32)) if1 ();
  hazard_stall_unit_if #(.CNT_W(4))  if3 ();

  hazard_stall_unit #(.STALL_CYCLES(1), .CNT_W(32)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  hazard_stall_unit #(.STALL_CYCLES(3), .CNT_W(4))  dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

  function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv1(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] irt, input logic uses, input logic br);
    if1.id_ex_mem_read = mr; if1.id_ex_rt = rt; if1.if_id_rs = rs;
    if1.if_id_rt = irt; if1.if_id_uses_rt = uses; if1.branch_taken = br;
  endtask

  task automatic drv3(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] irt, input logic uses, input logic br);
    if3.id_ex_mem_read = mr; if3.id_ex_rt = rt; if3.if_id_rs = rs;
    if3.if_id_rt = irt; if3.if_id_uses_rt = uses; if3.branch_taken = br;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [4:0] o1();
    return {if1.pc_write, if1.if_id_write, if1.id_ex_bubble, if1.if_id_flush, if1.stalling};
  endfunction

  function automatic logic [4:0] o3();
    return {if3.pc_write, if3.if_id_write, if3.id_ex_bubble, if3.if_id_flush, if3.stalling};
  endfunction

  initial begin
    drv1(0, 0, 0, 0, 0, 0);
    drv3(0, 0, 0, 0, 0, 0);
    #1;
    check("reset_out1", 32'(o1()), 32'(RSTV));
    check("reset_out3", 32'(o3()), 32'(RSTV));
    check("reset_scnt1", if1.stall_cnt, 32'd0);
    check("reset_fcnt3", 32'(if3.flush_cnt), 32'd0);
    step(); reset_n = 1'b1;

    // Single-cycle load-use on rs
    drv1(1, 8, 8, 0, 0, 0); #1 check("ldu_rs", 32'(o1()), 32'(STALV));
    step(); drv1(0, 8, 8, 0, 0, 0); #1 check("ldu_rs_after", 32'(o1()), 32'(PASS));
    check("ldu_rs_scnt", if1.stall_cnt, cexp(1));
    step(); drv1(1, 0, 0, 0, 0, 0); #1 check("reg_zero", 32'(o1()), 32'(PASS));
    step(); drv1(1, 9, 3, 9, 0, 0); #1 check("rt_unused", 32'(o1()), 32'(PASS));
    step(); drv1(1, 9, 3, 9, 1, 0); #1 check("rt_used", 32'(o1()), 32'(STALV));
    step(); drv1(0, 9, 3, 9, 1, 0); #1 check("rt_used_after", 32'(o1()), 32'(PASS));
    check("rt_used_scnt", if1.stall_cnt, cexp(2));
    step(); drv1(0, 0, 0, 0, 0, 1); #1 check("branch1", 32'(o1()), 32'(FLUSH));
    step(); drv1(1, 8, 8, 0, 0, 1); #1 check("branch_hazard", 32'(o1()), 32'(FLUSH));
    step(); drv1(0, 0, 0, 0, 0, 0); #1 check("branch_after", 32'(o1()), 32'(PASS));
    check("branch_fcnt", if1.flush_cnt, cexp(2));
    check("branch_scnt", if1.stall_cnt, cexp(2));

    // Three-cycle stall from a single hazard pulse
    step(); drv3(1, 8, 8, 0, 0, 0); #1 check("s3_c1", 32'(o3()), 32'(STALV));
    step(); drv3(0, 8, 8, 0, 0, 0); #1 check("s3_c2", 32'(o3()), 32'(STALV));
    step(); #1 check("s3_c3", 32'(o3()), 32'(STALV));
    step(); #1 check("s3_done", 32'(o3()), 32'(PASS));
    check("s3_scnt", 32'(if3.stall_cnt), cexp(3));

    // Branch in the second stall cycle cancels the rest of the stall
    step(); drv3(1, 8, 8, 0, 0, 0); #1 check("s3b_c1", 32'(o3()), 32'(STALV));
    step(); drv3(0, 8, 8, 0, 0, 1); #1 check("s3b_flush", 32'(o3()), 32'(FLUSH));
    step(); drv3(0, 8, 8, 0, 0, 0); #1 check("s3b_after", 32'(o3()), 32'(PASS));
    check("s3b_fcnt", 32'(if3.flush_cnt), cexp(1));
    check("s3b_scnt", 32'(if3.stall_cnt), cexp(4));

    // Held hazard: back-to-back fresh stalls, then saturation of the 4-bit counter
    step(); drv3(1, 12, 12, 0, 0, 0); #1 check("b2b_c1", 32'(o3()), 32'(STALV));
    step(); step(); step(); #1 check("b2b_fresh", 32'(o3()), 32'(STALV));
    for (int i = 0; i < 16; i++) step();
    drv3(0, 0, 0, 0, 0, 0);
    step(); step(); step(); #1 check("sat_out", 32'(o3()), 32'(PASS));
    check("sat_scnt", 32'(if3.stall_cnt), cexp(15));

    // Reset in the middle of a stall
    step(); drv3(1, 7, 7, 0, 0, 0); #1 check("rst_c1", 32'(o3()), 32'(STALV));
    step(); drv3(0, 0, 0, 0, 0, 0); #1 check("rst_c2", 32'(o3()), 32'(STALV));
    #2 reset_n = 1'b0;
    #1 check("rst_mid_out3", 32'(o3()), 32'(RSTV));
    check("rst_mid_out1", 32'(o1()), 32'(RSTV));
    check("rst_mid_scnt3", 32'(if3.stall_cnt), 32'd0);
    check("rst_mid_fcnt1", if1.flush_cnt, 32'd0);
    step(); reset_n = 1'b1;
    #1 check("rst_rel_out3", 32'(o3()), 32'(PASS));
    step(); #1 check("rst_rel2_out3", 32'(o3()), 32'(PASS));
    check("rst_rel_scnt3", 32'(if3.stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
